// File: rtl/vrf_writeback_arbiter.sv
// Vector register file writeback arbiter: ALU and load writebacks share one registered
// write port, plus a pending-write scoreboard that stalls issue on RAW/WAW hazards.
// Optional build macro: VRF_WB_RR_EN (round-robin on conflict; default is load-wins).
module vrf_writeback_arbiter #(
  parameter int REGSIZE       = 15,
  parameter int VECTORSPERREG = 4,
  parameter int DATAWIDTH     = 16,
  parameter int REGSIZEINT    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     alu_valid,
  output logic                                     alu_ready,
  input  logic [REGSIZEINT-1:0]                    alu_rd,
  input  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  alu_wd,
  input  logic                                     mem_valid,
  output logic                                     mem_ready,
  input  logic [REGSIZEINT-1:0]                    mem_rd,
  input  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  mem_wd,
  input  logic                                     issue_valid,
  input  logic [REGSIZEINT-1:0]                    issue_rd,
  input  logic [REGSIZEINT-1:0]                    issue_rs1,
  input  logic [REGSIZEINT-1:0]                    issue_rs2,
  output logic                                     issue_stall,
  output logic                                     we3,
  output logic [REGSIZEINT-1:0]                    ra3,
  output logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]  wd3,
  output logic [REGSIZE-1:0]                       pending
);

  // One-hot of a register index; indices at or beyond REGSIZE map to all zeros.
  function automatic logic [REGSIZE-1:0] reg_onehot(input logic [REGSIZEINT-1:0] idx);
    reg_onehot = '0;
    for (int i = 0; i < REGSIZE; i++) begin
      if (idx == REGSIZEINT'(i)) reg_onehot[i] = 1'b1;
    end
  endfunction

  logic                                    mem_wins;
  logic                                    alu_acc;
  logic                                    mem_acc;
  logic                                    stage_take;
  logic                                    stage_write;
  logic [REGSIZEINT-1:0]                   stage_rd;
  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0] stage_wd;
  logic [REGSIZE-1:0]                      issue_hit;
  logic                                    issue_fire;
  logic [REGSIZE-1:0]                      set_mask;
  logic [REGSIZE-1:0]                      clr_mask;

`ifdef VRF_WB_RR_EN
  typedef enum logic {PREF_ALU, PREF_MEM} pref_t;

  pref_t pref_q;
  pref_t pref_d;

  // Every conflict grants someone, so the preference flips on each one.
  always_comb begin
    pref_d = pref_q;
    if (alu_valid && mem_valid) begin
      pref_d = (pref_q == PREF_ALU) ? PREF_MEM : PREF_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pref_q <= PREF_ALU;
    else        pref_q <= pref_d;
  end

  assign mem_wins = (pref_q == PREF_MEM);
`else
  assign mem_wins = 1'b1;
`endif

  assign alu_ready = alu_valid & ~(mem_valid & mem_wins);
  assign mem_ready = mem_valid & ~(alu_valid & ~mem_wins);
  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;

  always_comb begin
    stage_take = 1'b0;
    stage_rd   = alu_rd;
    stage_wd   = alu_wd;
    if (mem_acc) begin
      stage_take = 1'b1;
      stage_rd   = mem_rd;
      stage_wd   = mem_wd;
    end else if (alu_acc) begin
      stage_take = 1'b1;
    end
  end

  // Out-of-range destinations are accepted but never reach the register file.
  assign stage_write = stage_take & (|reg_onehot(stage_rd));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ra3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= stage_write;
      if (stage_write) begin
        ra3 <= stage_rd;
        wd3 <= stage_wd;
      end
    end
  end

  assign issue_hit   = pending & (reg_onehot(issue_rs1) | reg_onehot(issue_rs2) |
                                  reg_onehot(issue_rd));
  assign issue_stall = issue_valid & (|issue_hit);
  assign issue_fire  = issue_valid & ~issue_stall;
  assign set_mask    = issue_fire ? reg_onehot(issue_rd) : '0;
  assign clr_mask    = we3 ? reg_onehot(ra3) : '0;

  // Set is applied after clear so a same-edge issue keeps the register pending.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: tb/tb_vrf_writeback_arbiter.sv
// Directed bench for vrf_writeback_arbiter: a queue of expected VRF writes plus a
// reference model of the pending scoreboard, arbitration and stall outputs.
module tb_vrf_writeback_arbiter;

  localparam int REGSIZE = 15;
  localparam int VPR     = 4;
  localparam int DW      = 16;
  localparam int RI      = 4;

  typedef logic [VPR-1:0][DW-1:0] vec_t;
  typedef struct packed {
    logic [RI-1:0] rd;
    vec_t          wd;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid, alu_ready, mem_valid, mem_ready;
  logic [RI-1:0]    alu_rd, mem_rd;
  vec_t             alu_wd, mem_wd;
  logic             issue_valid, issue_stall;
  logic [RI-1:0]    issue_rd, issue_rs1, issue_rs2;
  logic             we3;
  logic [RI-1:0]    ra3;
  vec_t             wd3;
  logic [REGSIZE-1:0] pending;

  wr_t                sbq[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [REGSIZE-1:0] exp_pend = '0;
  logic [REGSIZE-1:0] next_pend = '0;
  logic               rr_ptr = 1'b0;
  logic               a_acc, m_acc;
  logic               alu_done;
  int                 mem_idx;

  vrf_writeback_arbiter #(
    .REGSIZE(REGSIZE), .VECTORSPERREG(VPR), .DATAWIDTH(DW), .REGSIZEINT(RI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .we3(we3), .ra3(ra3), .wd3(wd3), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic vec_t lanes(input logic [DW-1:0] v);
    return {VPR{v}};
  endfunction

  function automatic logic [REGSIZE-1:0] one_hot(input logic [RI-1:0] idx);
    return (int'(idx) < REGSIZE) ? (REGSIZE'(1) << idx) : '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle: check what the last edge produced, then drive and check combinational outputs.
  task automatic applyStimulus(
    input logic rstv,
    input logic av, input logic [RI-1:0] ard, input vec_t awd,
    input logic mv, input logic [RI-1:0] mrd, input vec_t mwd,
    input logic iv, input logic [RI-1:0] ird, input logic [RI-1:0] irs1,
    input logic [RI-1:0] irs2,
    output logic aacc, output logic macc);
    wr_t                e;
    logic               grant_mem, exp_ar, exp_mr, exp_stall;
    logic [REGSIZE-1:0] clr_mask, set_mask;

    @(negedge clk);
    exp_pend = next_pend;
    checkOutput("pending", 128'(pending), 128'(exp_pend));
    checkOutput("we3", 128'(we3), 128'(sbq.size() != 0));
    clr_mask = '0;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput("ra3", 128'(ra3), 128'(e.rd));
      checkOutput("wd3", 128'(wd3), 128'(e.wd));
      clr_mask = one_hot(e.rd);
    end

    rst_n = rstv;
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    mem_valid = mv; mem_rd = mrd; mem_wd = mwd;
    issue_valid = iv; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    #1;

    aacc = 1'b0;
    macc = 1'b0;
    if (rstv) begin
`ifdef VRF_WB_RR_EN
      grant_mem = rr_ptr;
      if (av && mv) rr_ptr = ~rr_ptr;
`else
      grant_mem = 1'b1;
`endif
      exp_mr = mv & (~av | grant_mem);
      exp_ar = av & (~mv | ~grant_mem);
      if (av) checkOutput("alu_ready", 128'(alu_ready), 128'(exp_ar));
      if (mv) checkOutput("mem_ready", 128'(mem_ready), 128'(exp_mr));
      aacc = exp_ar;
      macc = exp_mr;
      if (aacc && int'(ard) < REGSIZE) sbq.push_back('{rd: ard, wd: awd});
      if (macc && int'(mrd) < REGSIZE) sbq.push_back('{rd: mrd, wd: mwd});

      exp_stall = iv & (|(exp_pend & (one_hot(irs1) | one_hot(irs2) | one_hot(ird))));
      checkOutput("issue_stall", 128'(issue_stall), 128'(exp_stall));
      set_mask  = (iv && !exp_stall) ? one_hot(ird) : '0;
      next_pend = (exp_pend & ~clr_mask) | set_mask;
    end else begin
      next_pend = '0;
      rr_ptr    = 1'b0;
    end
  endtask

  task automatic idleCycle();
    logic a, m;
    applyStimulus(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 4'd0, a, m);
  endtask

  task automatic aluWrite(input logic [RI-1:0] rd, input logic [DW-1:0] v,
                          input logic iv, input logic [RI-1:0] ird,
                          input logic [RI-1:0] irs1);
    logic a, m;
    applyStimulus(1'b1, 1'b1, rd, lanes(v), 1'b0, 4'd0, '0, iv, ird, irs1, 4'd0, a, m);
  endtask

  task automatic issueOnly(input logic [RI-1:0] ird, input logic [RI-1:0] irs1,
                           input logic [RI-1:0] irs2);
    logic a, m;
    applyStimulus(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b1, ird, irs1, irs2, a, m);
  endtask

  initial begin
    // Reset held two cycles with every request asserted.
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd3; alu_wd = lanes(16'h1234);
    mem_valid = 1'b1; mem_rd = 4'd4; mem_wd = lanes(16'h5678);
    issue_valid = 1'b1; issue_rd = 4'd5; issue_rs1 = 4'd0; issue_rs2 = 4'd0;
    repeat (2) @(posedge clk);

    $display("[TB] single ALU write");
    aluWrite(4'd3, 16'hABCD, 1'b0, 4'd0, 4'd0);
    idleCycle();
    idleCycle();

    $display("[TB] ALU/load conflict");
    alu_done = 1'b0;
    mem_idx  = 0;
    for (int c = 0; c < 6 && !(alu_done && mem_idx == 2); c++) begin
      applyStimulus(1'b1, !alu_done, 4'd1, lanes(16'h1111),
                    mem_idx < 2, (mem_idx == 0) ? 4'd2 : 4'd6,
                    (mem_idx == 0) ? lanes(16'h2222) : lanes(16'h6666),
                    1'b0, 4'd0, 4'd0, 4'd0, a_acc, m_acc);
      if (a_acc) alu_done = 1'b1;
      if (m_acc) mem_idx++;
    end
    applyStimulus(1'b1, 1'b1, 4'd10, lanes(16'hAAAA), 1'b1, 4'd11, lanes(16'hBBBB),
                  1'b0, 4'd0, 4'd0, 4'd0, a_acc, m_acc);
    aluWrite(4'd10, 16'hAAAA, 1'b0, 4'd0, 4'd0);
    idleCycle();
    idleCycle();

    $display("[TB] scoreboard hazard");
    issueOnly(4'd5, 4'd0, 4'd0);
    issueOnly(4'd9, 4'd5, 4'd0);
    issueOnly(4'd9, 4'd5, 4'd0);
    aluWrite(4'd5, 16'h5555, 1'b1, 4'd9, 4'd5);
    issueOnly(4'd9, 4'd5, 4'd0);
    issueOnly(4'd9, 4'd5, 4'd0);
    issueOnly(4'd1, 4'd9, 4'd2);

    $display("[TB] set/clear collision");
    aluWrite(4'd7, 16'h7777, 1'b0, 4'd0, 4'd0);
    issueOnly(4'd7, 4'd0, 4'd0);
    idleCycle();
    issueOnly(4'd3, 4'd7, 4'd0);

    $display("[TB] out-of-range and reset");
    aluWrite(4'd15, 16'hFFFF, 1'b0, 4'd0, 4'd0);
    issueOnly(4'd15, 4'd15, 4'd15);
    idleCycle();
    aluWrite(4'd4, 16'h4444, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd8, lanes(16'h8888), 1'b0, 4'd0, '0,
                  1'b0, 4'd0, 4'd0, 4'd0, a_acc, m_acc);
    idleCycle();
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
